// File: rtl/and3_response_checker.sv
// and3_response_checker
// Receiving end of the exhaustive stimulus run for a 3-input AND gate.
// Accepts (a, b, c, s) tuples over valid/ready and checks s == a & b & c.
// It records which of the 8 input combinations were seen and counts
// mismatches with saturation. An idle timeout catches a stalled source.
// Optional feature macro: FIRST_ERR_LOG_EN. When it is defined, the checker
// also logs {a,b,c,s} of the first mismatch and adds the first_err and
// first_err_valid ports.
module and3_response_checker #(
   parameter int unsigned ERR_W   = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_a,
   input  logic             in_b,
   input  logic             in_c,
   input  logic             in_s,
   output logic [7:0]       coverage,
   output logic [ERR_W-1:0] err_count,
   output logic             timeout,
   output logic             done,
   output logic             pass
`ifdef FIRST_ERR_LOG_EN
   ,
   output logic [3:0]       first_err,
   output logic             first_err_valid
`endif
);

   // The idle counter only has to reach TIMEOUT. One bit is enough when the timeout is off.
   localparam int unsigned IDLE_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] TIMEOUT_CNT = IDLE_W'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   state_e             state_q,     state_d;
   logic [7:0]         coverage_q,  coverage_d;
   logic [ERR_W-1:0]   err_count_q, err_count_d;
   logic               timeout_q,   timeout_d;
   logic [IDLE_W-1:0]  idle_cnt_q,  idle_cnt_d;
`ifdef FIRST_ERR_LOG_EN
   logic [3:0]         first_err_q,       first_err_d;
   logic               first_err_valid_q, first_err_valid_d;
`endif

   logic [2:0]         combo;
   logic               mismatch;
   logic [IDLE_W-1:0]  idle_inc;

   assign combo    = {in_a, in_b, in_c};
   assign mismatch = in_s != (in_a & in_b & in_c);
   assign idle_inc = idle_cnt_q + 1'b1;

   // Next-state logic: start clears and (re)enters RUN. In RUN, either a transfer is checked or the idle counter advances.
   always_comb begin
      // NOTE: every _d gets its hold value first. Then no path leaves a
      // signal unassigned and no latch is inferred.
      state_d     = state_q;
      coverage_d  = coverage_q;
      err_count_d = err_count_q;
      timeout_d   = timeout_q;
      idle_cnt_d  = idle_cnt_q;
`ifdef FIRST_ERR_LOG_EN
      first_err_d       = first_err_q;
      first_err_valid_d = first_err_valid_q;
`endif

      if (start) begin
         // Clear wins over any sample presented in the same cycle.
         state_d     = ST_RUN;
         coverage_d  = '0;
         err_count_d = '0;
         timeout_d   = 1'b0;
         idle_cnt_d  = '0;
`ifdef FIRST_ERR_LOG_EN
         first_err_d       = '0;
         first_err_valid_d = 1'b0;
`endif
      end else if (state_q == ST_RUN) begin
         if (in_valid) begin
            coverage_d[combo] = 1'b1;
            idle_cnt_d        = '0;
            if (mismatch && (err_count_q != '1)) begin
               err_count_d = err_count_q + 1'b1;
            end
`ifdef FIRST_ERR_LOG_EN
            if (mismatch && !first_err_valid_q) begin
               first_err_d       = {in_a, in_b, in_c, in_s};
               first_err_valid_d = 1'b1;
            end
`endif
            if (coverage_d == 8'hFF) begin
               state_d = ST_DONE;
            end
         end else if (TIMEOUT != 0) begin
            idle_cnt_d = idle_inc;
            if (idle_inc == TIMEOUT_CNT) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
      end
   end

   // State and result registers. Asynchronous reset drops every output at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         coverage_q  <= '0;
         err_count_q <= '0;
         timeout_q   <= 1'b0;
         idle_cnt_q  <= '0;
`ifdef FIRST_ERR_LOG_EN
         first_err_q       <= '0;
         first_err_valid_q <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments let all registers update together
         // from the values they held before the edge.
         state_q     <= state_d;
         coverage_q  <= coverage_d;
         err_count_q <= err_count_d;
         timeout_q   <= timeout_d;
         idle_cnt_q  <= idle_cnt_d;
`ifdef FIRST_ERR_LOG_EN
         first_err_q       <= first_err_d;
         first_err_valid_q <= first_err_valid_d;
`endif
      end
   end

   // Outputs are registered or decoded only from registered state.
   assign in_ready  = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign coverage  = coverage_q;
   assign err_count = err_count_q;
   assign timeout   = timeout_q;
   assign pass      = done & (coverage_q == 8'hFF) & (err_count_q == '0) & ~timeout_q;
`ifdef FIRST_ERR_LOG_EN
   assign first_err       = first_err_q;
   assign first_err_valid = first_err_valid_q;
`endif

endmodule

// File: doc/and3_response_checker.md
# and3_response_checker

Sequential response checker for the 3-input AND gate under test (((a & b) & c) = s). It is the receiving end of the exhaustive stimulus sequence: it accepts sampled (a, b, c, s) tuples over a valid/ready handshake and compares each s against the expected AND function. It records which of the 8 input combinations have been exercised, counts mismatches and detects a stalled stimulus source. It sits between the stimulus driver and the bench's pass/fail reporting, replacing manual inspection of monitor output.

## Interface
- ERR_W, 8, width of the saturating mismatch counter (≥1)
- TIMEOUT, 16, idle cycles allowed in RUN with no transfer before abort; 0 disables the timeout
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- start  input  1  single-cycle pulse; clears results and enters RUN
- in_valid  input  1  sample tuple present
- in_ready  output  1  checker accepts a sample (high only in RUN)
- in_a, in_b, in_c  input  1 each  stimulus applied to the gate
- in_s  input  1  gate response
- coverage  output  8  bit {a,b,c} set once that combination has been accepted
- err_count  output  ERR_W  mismatches seen, saturating at all-ones
- timeout  output  1  RUN aborted by the idle timeout
- done  output  1  check complete (state DONE)
- pass  output  1  done, full coverage, zero errors, no timeout

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: in_ready=0. start → RUN and clears coverage, err_count, timeout and the idle counter.
- RUN: in_ready=1. A transfer occurs on a rising edge with in_valid & in_ready.
  - expected = in_a & in_b & in_c. If in_s != expected, err_count increments. The counter saturates at 2^ERR_W−1 and never wraps.
  - coverage[{in_a,in_b,in_c}] ← 1. Repeated combinations are still checked but do not alter coverage.
  - If a transfer makes coverage 8'hFF, the next state is DONE.
  - Each cycle without a transfer increments the idle counter, and a transfer clears it. If TIMEOUT≠0 and the counter reaches TIMEOUT, timeout←1 and the next state is DONE.
- DONE: in_ready=0. Results hold. start → RUN with a full clear. Any in_valid is ignored.
- start in RUN restarts the check. This means a clear and staying in RUN. A transfer in the same cycle is discarded, because the clear wins.
- pass = done & (coverage==8'hFF) & (err_count==0) & ~timeout, decoded from registered state.
- Asynchronous reset mid-RUN: all outputs drop to reset values immediately. Any partial check is lost.

## Timing
- Reset values: in_ready=0, coverage=0, err_count=0, timeout=0, done=0, pass=0.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Latency: a transfer at edge N is reflected in coverage and err_count after edge N. The completing transfer at edge N gives done=1 and in_ready=0 after edge N. The checker never accepts a 9th sample after coverage completes.
- in_ready rises the cycle after start is sampled in IDLE or DONE.
- Timeout: with no transfers after entering RUN, done and timeout assert after edge TIMEOUT.
- Handshake: the source holds its tuple until a transfer. The checker takes at most one sample per cycle and samples at full rate with no back-pressure bubbles.

## Configuration
- FIRST_ERR_LOG_EN defined: adds output first_err  output  4  holding {a,b,c,s} of the first mismatching transfer since start/reset.
  - Also adds first_err_valid  output  1.
  - Both reset and clear to 0 on start. Later mismatches do not overwrite them.
- FIRST_ERR_LOG_EN undefined: these ports and their registers do not exist. All other behaviour is identical.

## Test plan
- Reset then start, followed by the 8 correct tuples 000→0 … 111→1 at one per cycle → done=1 one cycle after the 8th, coverage=8'hFF, err_count=0, pass=1.
- The same sequence with tuple 011 sent with s=1 and 111 with s=0 → err_count=2, pass=0. With FIRST_ERR_LOG_EN: first_err=4'b0111, first_err_valid=1.
- Only 7 combinations sent (110 omitted), then idle with TIMEOUT=16 → done and timeout assert 16 cycles after the last transfer, coverage=8'hBF, pass=0.
- Duplicates: 000 sent 5 times, then all 8 → stays in RUN until 111 is accepted, err_count=0, pass=1. Also ERR_W=2 with 6 bad tuples → err_count saturates at 3.
- rst_n pulled low for half a cycle after 4 transfers → all outputs read 0 immediately. The checker is in IDLE, in_ready=0, and in_valid is ignored until start.
- start in DONE, and start together with in_valid in RUN → full clear, the coincident sample is not counted, and in_ready=1 on the following cycle.
